// File: rtl/patch2x2_gen_if.sv
// Pixel-in / patch-out stream bundle for patch2x2_gen.
// The master side feeds pixels and observes patches; the slave side is the block.
interface patch2x2_gen_if;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic        i_sof;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_err;

  modport master (
    output i_data, i_data_valid, i_sof,
    input  o_ready, o_data, o_data_valid, o_err
  );

  modport slave (
    input  i_data, i_data_valid, i_sof,
    output o_ready, o_data, o_data_valid, o_err
  );
endinterface

// File: rtl/patch2x2_gen.sv
// Raster-order 2x2 patch generator built around a single line buffer.
// Define PATCH2X2_EDGE_REPLICATE_EN to replicate right/bottom edge pixels instead of using zero.
module patch2x2_gen #(
  parameter logic [11:0] sourceImageWidth = 12'd640,
  parameter logic [11:0] sourceImgHeight  = 12'd480
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  patch2x2_gen_if.slave  bus
);

  localparam int          AW     = $clog2(int'(sourceImageWidth));
  localparam logic [11:0] X_LAST = sourceImageWidth - 12'd1;
  localparam logic [11:0] Y_LAST = sourceImgHeight - 12'd1;

`ifdef PATCH2X2_EDGE_REPLICATE_EN
  localparam bit REPLICATE = 1'b1;
`else
  localparam bit REPLICATE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FILL, RUN, EOL, FLUSH} state_t;

  state_t      state_reg, state_next;
  logic [11:0] x_reg, x_next, y_reg, y_next, x_inc;
  logic        tail_reg, tail_next;
  logic        valid_reg, right_reg, bottom_reg, err_reg;
  logic        emit_next, right_next, bottom_next, err_set;
  logic        ram_we, ram_re, shift_en, pix_en, ready, accept;
  logic [AW-1:0] ram_addr;
  logic [7:0]  rd_reg, pix_reg, prev_rd_reg, prev_pix_reg;
  logic [7:0]  d11, d12, d21, d22;
  logic [7:0]  line_mem [0:sourceImageWidth-1];

  assign ready  = (state_reg == IDLE) || (state_reg == FILL) || (state_reg == RUN);
  assign accept = bus.i_data_valid && ready;
  assign x_inc  = x_reg + 12'd1;

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    tail_next   = tail_reg;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = x_reg[AW-1:0];
    shift_en    = 1'b0;
    pix_en      = 1'b0;
    emit_next   = 1'b0;
    right_next  = 1'b0;
    bottom_next = 1'b0;
    err_set     = bus.i_data_valid && !ready;
    case (state_reg)
      IDLE: begin
        if (accept && bus.i_sof) begin
          ram_we     = 1'b1;
          ram_addr   = '0;
          x_next     = 12'd1;
          y_next     = 12'd0;
          state_next = FILL;
        end
      end
      FILL, RUN: begin
        if (accept && bus.i_sof) begin
          // A new frame start mid-frame: drop the old frame and restart at (0,0)
          err_set    = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = '0;
          x_next     = 12'd1;
          y_next     = 12'd0;
          state_next = FILL;
        end else if (accept) begin
          ram_we = 1'b1;
          if (state_reg == RUN) begin
            ram_re    = 1'b1;
            shift_en  = 1'b1;
            pix_en    = 1'b1;
            emit_next = (x_reg != 12'd0);
          end
          if (x_reg == X_LAST) begin
            x_next     = 12'd0;
            state_next = (state_reg == RUN) ? EOL : RUN;
          end else begin
            x_next = x_inc;
          end
        end
      end
      EOL: begin
        // Pre-read column 0 so a following flush starts with it already registered
        ram_addr   = '0;
        ram_re     = 1'b1;
        shift_en   = 1'b1;
        emit_next  = 1'b1;
        right_next = 1'b1;
        y_next     = y_reg + 12'd1;
        x_next     = 12'd0;
        tail_next  = 1'b0;
        state_next = (y_reg + 12'd1 == Y_LAST) ? FLUSH : RUN;
      end
      FLUSH: begin
        if (tail_reg) begin
          state_next = IDLE;
          x_next     = 12'd0;
          y_next     = 12'd0;
          tail_next  = 1'b0;
        end else begin
          ram_addr    = x_inc[AW-1:0];
          ram_re      = (x_reg != X_LAST);
          shift_en    = 1'b1;
          emit_next   = 1'b1;
          bottom_next = 1'b1;
          right_next  = (x_reg == X_LAST);
          if (x_reg == X_LAST) begin
            x_next    = 12'd0;
            tail_next = 1'b1;
          end else begin
            x_next = x_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read-before-write line buffer; the registered read feeds the patch directly
  always_ff @(posedge i_clk) begin
    if (ram_we)
      line_mem[ram_addr] <= bus.i_data;
    if (ram_re)
      rd_reg <= line_mem[ram_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      x_reg        <= 12'd0;
      y_reg        <= 12'd0;
      tail_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      right_reg    <= 1'b0;
      bottom_reg   <= 1'b0;
      err_reg      <= 1'b0;
      pix_reg      <= 8'd0;
      prev_rd_reg  <= 8'd0;
      prev_pix_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      tail_reg   <= tail_next;
      valid_reg  <= emit_next;
      right_reg  <= right_next;
      bottom_reg <= bottom_next;
      err_reg    <= err_reg | err_set;
      if (shift_en) begin
        prev_rd_reg  <= rd_reg;
        prev_pix_reg <= pix_reg;
      end
      if (pix_en)
        pix_reg <= bus.i_data;
    end
  end

  // Out-of-image neighbours take the nearest in-image value or zero
  assign d11 = prev_rd_reg;
  assign d12 = right_reg  ? (REPLICATE ? d11 : 8'd0) : rd_reg;
  assign d21 = bottom_reg ? (REPLICATE ? d11 : 8'd0) : prev_pix_reg;
  assign d22 = right_reg  ? (REPLICATE ? d21 : 8'd0) :
               bottom_reg ? (REPLICATE ? d12 : 8'd0) : pix_reg;

  assign bus.o_data       = valid_reg ? {d22, d12, d21, d11} : 32'd0;
  assign bus.o_data_valid = valid_reg;
  assign bus.o_ready      = ready;
  assign bus.o_err        = err_reg;

endmodule

// File: tb/tb_patch2x2_gen.sv
// Scoreboard bench for patch2x2_gen: a geometric reference model queues expected
// patches per frame while a monitor compares every o_data_valid pulse.
module tb_patch2x2_gen;
  localparam int W = 4;
  localparam int H = 3;

`ifdef PATCH2X2_EDGE_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  patch2x2_gen_if bus();

  patch2x2_gen #(
    .sourceImageWidth(12'(W)),
    .sourceImgHeight (12'(H))
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0]  img [H][W];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int ready_low = 0;

  function automatic logic [7:0] edge_px(input logic [7:0] v);
    return REP ? v : 8'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  // Expected patches of the current img; cut = pixels of this frame accepted before it ended
  task automatic expect_frame(input int cut);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [7:0] p11, p12, p21, p22;
        bit right, bottom, emitted;
        int nx;
        right  = (x == W - 1);
        bottom = (y == H - 1);
        p11 = img[y][x];
        p12 = right  ? edge_px(p11) : img[y][x + 1];
        p21 = bottom ? edge_px(p11) : img[y + 1][x];
        if (right && bottom)
          p22 = edge_px(p11);
        else if (right)
          p22 = edge_px(p21);
        else if (bottom)
          p22 = edge_px(p12);
        else
          p22 = img[y + 1][x + 1];
        nx = right ? x : x + 1;
        if (cut >= W * H)
          emitted = 1'b1;
        else if (bottom)
          emitted = 1'b0;
        else
          emitted = ((y + 1) * W + nx) < cut;
        if (emitted)
          exp_q.push_back({p22, p12, p21, p11});
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_data_valid) begin
      got_q.push_back(bus.o_data);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL patch_unexpected: got %h, required no patch", bus.o_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.o_data !== e) begin
          n_miss++;
          $display("FAIL patch: got %h, required %h", bus.o_data, e);
        end else
          $display("ok   patch: %h", e);
      end
    end
    if (i_rst_n && !bus.o_ready)
      ready_low++;
  end

  // Called at a negedge; returns at the negedge right after the acceptance edge
  task automatic push_pixel(input logic [7:0] d, input logic s, input int gap);
    int t;
    t = 0;
    for (int g = 0; g < gap; g++) begin
      bus.i_data_valid = 1'b0;
      @(negedge i_clk);
    end
    while (!bus.o_ready) begin
      bus.i_data_valid = 1'b0;
      @(negedge i_clk);
      t++;
      if (t > 2000) begin
        $display("FAIL ready_timeout: got o_ready=0 for %0d cycles, required 1", t);
        $fatal(1, "ready never returned");
      end
    end
    bus.i_data       = d;
    bus.i_sof        = s;
    bus.i_data_valid = 1'b1;
    @(negedge i_clk);
    bus.i_data_valid = 1'b0;
    bus.i_sof        = 1'b0;
  endtask

  task automatic fill_img(input bit seq);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = seq ? 8'(y * W + x) : 8'($urandom);
  endtask

  task automatic drive_frame(input int npix, input int gap_max, input int poke_row);
    for (int i = 0; i < npix; i++) begin
      push_pixel(img[i / W][i % W], (i == 0), (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
      if (poke_row > 0 && i == poke_row * W + W - 1) begin
        // This cycle is the end-of-line bubble: the offered pixel must be dropped
        bus.i_data       = 8'hEE;
        bus.i_data_valid = 1'b1;
        @(negedge i_clk);
        bus.i_data_valid = 1'b0;
        check("err_after_eol_valid", 32'(bus.o_err), 32'd1);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge i_clk);
      #1;
      t++;
    end while (!(exp_q.size() == 0 && bus.o_ready) && t < 2000);
    if (t >= 2000) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d patches pending, required 0", exp_q.size());
    end
    check("pending_patches", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_data       = 8'd0;
    bus.i_data_valid = 1'b0;
    bus.i_sof        = 1'b0;
    i_rst_n          = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_valid", 32'(bus.o_data_valid), 32'd0);
    check("reset_data", bus.o_data, 32'd0);
    check("reset_err", 32'(bus.o_err), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Sequential frame 0..11, valid offered whenever ready
    fill_img(1'b1);
    got_q.delete();
    ready_low = 0;
    expect_frame(W * H);
    drive_frame(W * H, 0, 0);
    drain();
    repeat (2) @(negedge i_clk);
    check("ready_low_cycles", 32'(ready_low), 32'((H - 1) + W + 1));
    check("patch_count", 32'(got_q.size()), 32'(W * H));
    if (got_q.size() == W * H) begin
      check("patch_0_0", got_q[0], 32'h05_01_04_00);
      check("patch_3_0", got_q[3], REP ? 32'h07_03_07_03 : 32'h00_00_07_03);
      check("patch_3_2", got_q[11], REP ? 32'h0B_0B_0B_0B : 32'h00_00_00_0B);
    end
    check("err_clean_frame", 32'(bus.o_err), 32'd0);

    // Random pixels with random valid gaps
    for (int f = 0; f < 4; f++) begin
      fill_img(1'b0);
      expect_frame(W * H);
      drive_frame(W * H, 3, 0);
      drain();
    end
    check("err_random_frames", 32'(bus.o_err), 32'd0);

    // Reset pulse in the middle of the flush
    fill_img(1'b0);
    expect_frame(W * H);
    drive_frame(W * H, 0, 0);
    repeat (2) @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("flush_rst_valid", 32'(bus.o_data_valid), 32'd0);
    check("flush_rst_ready", 32'(bus.o_ready), 32'd1);
    check("flush_rst_data", bus.o_data, 32'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    fill_img(1'b0);
    expect_frame(W * H);
    drive_frame(W * H, 2, 0);
    drain();

    // Valid during the end-of-line bubble
    fill_img(1'b0);
    got_q.delete();
    expect_frame(W * H);
    drive_frame(W * H, 1, 1);
    drain();
    check("eol_patch_count", 32'(got_q.size()), 32'(W * H));
    check("err_sticky", 32'(bus.o_err), 32'd1);

    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("err_cleared_by_reset", 32'(bus.o_err), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Second start-of-frame at pixel 6 abandons the old frame
    fill_img(1'b1);
    got_q.delete();
    expect_frame(6);
    drive_frame(6, 0, 0);
    fill_img(1'b0);
    expect_frame(W * H);
    drive_frame(W * H, 0, 0);
    drain();
    check("restart_err", 32'(bus.o_err), 32'd1);
    check("restart_patch_count", 32'(got_q.size()), 32'(1 + W * H));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/patch2x2_gen.md
PATCH2X2_GEN -- requirements
Module: patch2x2_gen

Interface
REQ-001 The block SHALL expose parameter sourceImageWidth, default 12'd640, meaning source pixels per line (legal range 2..4095).
REQ-002 The block SHALL expose parameter sourceImgHeight, default 12'd480, meaning source lines per frame (legal range 2..4095).
REQ-003 Port i_clk  input  1  is the single clock; every flop is rising-edge.
REQ-004 Port i_rst_n  input  1  is the reset: asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-005 Port i_data  input  8  is the source grey pixel, in raster order.
REQ-006 Port i_data_valid  input  1  qualifies i_data; a pixel is accepted only when i_data_valid and o_ready are both 1.
REQ-007 Port i_sof  input  1  marks the first pixel of a frame and is sampled with i_data_valid.
REQ-008 Port o_ready  output  1  indicates the block can accept a pixel this cycle.
REQ-009 Port o_data  output  32  carries the 2x2 patch {Data22, Data12, Data21, Data11}; Data11=(x,y), Data12=(x+1,y), Data21=(x,y+1), Data22=(x+1,y+1).
REQ-010 Port o_data_valid  output  1  qualifies o_data; one pulse per patch.
REQ-011 Port o_err  output  1  is a sticky error flag.

Function
REQ-012 Per frame, the block SHALL emit exactly sourceImageWidth*sourceImgHeight patches, anchored at (x,y) in raster order.
REQ-013 The block SHALL hold one line buffer of sourceImageWidth bytes, read-before-write at the same address.
REQ-014 FSM states SHALL be IDLE, FILL, RUN, EOL and FLUSH.
REQ-015 IDLE: o_ready=1; an accepted pixel with i_sof=1 is written to the line buffer at x=0 and the FSM enters FILL; accepted pixels without i_sof are discarded silently.
REQ-016 FILL: row 0 is written to the line buffer with no output; after x=sourceImageWidth-1 is accepted, the FSM enters RUN.
REQ-017 RUN, accepting pixel (x,y+1): read line buffer[x] (row y), write the new pixel, and register both; x=0 emits nothing; x>=1 emits patch (x-1,y) one cycle after acceptance.
REQ-018 After accepting x=sourceImageWidth-1, the FSM SHALL enter EOL for exactly one cycle with o_ready=0 and emit patch (W-1,y), using Data12=Data11 and Data22=Data21.
REQ-019 From EOL, the FSM SHALL return to RUN, or enter FLUSH if y+1 equals sourceImgHeight-1.
REQ-020 FLUSH: o_ready=0 for sourceImageWidth+1 cycles; row H-1 is emitted back-to-back from the line buffer, first patch in the second FLUSH cycle, using Data21=Data11 and Data22=Data12; the FSM then enters IDLE.
REQ-021 Output latency SHALL be one cycle from the triggering acceptance (or EOL/FLUSH cycle) to o_data_valid.
REQ-022 Ready-low cycles per frame SHALL total (sourceImgHeight-1)+sourceImageWidth+1.
REQ-023 i_data_valid=1 while o_ready=0 SHALL drop the pixel and set o_err.
REQ-024 Accepted i_sof=1 in FILL or RUN SHALL set o_err, abandon the frame without emitting further patches, and restart FILL with this pixel as (0,0).
REQ-025 x/y counters SHALL wrap to 0 at width-1 and height-1; they are 12-bit.

Reset
REQ-026 While i_rst_n=0: o_data=0, o_data_valid=0, o_err=0, o_ready=1, FSM=IDLE, counters=0; line buffer contents are don't-care.
REQ-027 Reset asserted mid-frame SHALL abort immediately; no partial patch is emitted after release.

Configuration
REQ-028 Macro PATCH2X2_EDGE_REPLICATE_EN defined: right-column and bottom-row neighbours SHALL be replicated as in REQ-018/REQ-020.
REQ-029 Macro PATCH2X2_EDGE_REPLICATE_EN undefined: those out-of-image neighbours SHALL be 8'd0 instead; timing and counts are unchanged.

Verification
REQ-030 Run with W=4, H=3, pixels 0..11 with i_sof on 0 and valid held high: 12 patches are produced; patch (0,0) = 32'h05_01_04_00; ready-low cycles total 7.
REQ-031 Same stimulus with the replicate macro: patch (3,0) = 32'h07_03_07_03 and patch (3,2) = 32'h0B_0B_0B_0B; without the macro, patch (3,2) = 32'h00_00_00_0B.
REQ-032 Drive valid during an EOL cycle: that pixel is dropped, o_err=1 and stays 1, and patch count is unchanged.
REQ-033 Second i_sof at pixel 6 of a frame: o_err=1, no patches from the old frame follow, and the new frame yields 12 correct patches.
REQ-034 Pulse i_rst_n low during FLUSH: o_data_valid=0 at once, o_ready=1, and the next full frame is correct.
REQ-035 Random valid gaps with W=640, H=480 checked against a reference model: 307200 patches, bit-exact.
